// File: rtl/bus_arbiter_pkg.sv
// Shared constants for the CPU/DMA bus arbiter: owner encoding, counter width and
// Peripheral register addresses used by the arbiter's environment.
package bus_arbiter_pkg;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam int unsigned CNT_WIDTH = 4;

  localparam logic [31:0] ADDR_TH     = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL     = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON   = 32'h4000_0008;
  localparam logic [31:0] ADDR_LED    = 32'h4000_000C;
  localparam logic [31:0] ADDR_SWITCH = 32'h4000_0010;
  localparam logic [31:0] ADDR_DIGI   = 32'h4000_0014;

endpackage

// File: rtl/bus_arbiter_if.sv
// Bundle of CPU, DMA and Peripheral-side signals around the bus arbiter.
// slave is the arbiter's view; master is the view of the CPU/DMA/Peripheral side.
interface bus_arbiter_if;

  logic        cpu_rd;
  logic        cpu_wr;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  logic        dma_req;
  logic        dma_wr;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic [31:0] dma_rdata;
  logic        dma_rvalid;

  logic        bus_rd;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  logic        owner;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_wr, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output bus_rd, bus_wr, bus_addr, bus_wdata,
    input  bus_rdata,
    output owner
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_wr, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  bus_rd, bus_wr, bus_addr, bus_wdata,
    output bus_rdata,
    input  owner
  );

endinterface

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear and synchronous active-low reset.
module arb_sat_counter #(
    parameter int unsigned Width = 4,
    parameter int unsigned Limit = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [Width-1:0] count,
    output logic             at_limit
);

    localparam logic [Width-1:0] LimitW = Width'(Limit);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && !at_limit) begin
            count_q <= count_q + Width'(1);
        end
    end

    always_comb begin
        count    = count_q;
        at_limit = (count_q == LimitW);
    end

endmodule

// File: rtl/bus_arbiter.sv
// Same-cycle arbiter sharing the Peripheral/DataMem bus between the CPU data port and a
// DMA master, with bounded DMA bursts under contention and bounded DMA starvation.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned BURST_MAX    = 4
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.slave  bus
);

    logic                 cpu_req;
    logic                 cpu_win;
    logic                 dma_win;
    logic                 dma_rd_grant;
    logic                 owner_q;
    logic [31:0]          dma_rdata_q;
    logic                 dma_rvalid_q;
    logic [CNT_WIDTH-1:0] burst_cnt;
    logic [CNT_WIDTH-1:0] starve_cnt;
    logic                 burst_at_max;
    logic                 starve_at_limit;
    logic                 unused_cnt;

    arb_sat_counter #(
        .Width (CNT_WIDTH),
        .Limit (BURST_MAX)
    ) u_burst_cnt (
        .clk      (clk),
        .reset    (reset),
        .inc      (dma_win),
        .clr      (!dma_win),
        .count    (burst_cnt),
        .at_limit (burst_at_max)
    );

    arb_sat_counter #(
        .Width (CNT_WIDTH),
        .Limit (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk      (clk),
        .reset    (reset),
        .inc      (cpu_win && bus.dma_req),
        .clr      (dma_win || !bus.dma_req),
        .count    (starve_cnt),
        .at_limit (starve_at_limit)
    );

    // Counts saturate at their limits, so at_limit is the whole decision input.
    assign unused_cnt = ^{burst_cnt, starve_cnt};

    always_comb begin
        cpu_req = bus.cpu_rd | bus.cpu_wr;
        cpu_win = 1'b0;
        dma_win = 1'b0;
        if (reset) begin
            if (cpu_req && bus.dma_req) begin
                dma_win = ((owner_q == OWN_DMA) && !burst_at_max) || starve_at_limit;
                cpu_win = !dma_win;
            end else begin
                dma_win = bus.dma_req;
                cpu_win = cpu_req;
            end
        end
        dma_rd_grant = dma_win && !bus.dma_wr;
    end

    always_comb begin
        bus.bus_rd    = 1'b0;
        bus.bus_wr    = 1'b0;
        bus.bus_addr  = '0;
        bus.bus_wdata = '0;
        if (dma_win) begin
            bus.bus_rd    = !bus.dma_wr;
            bus.bus_wr    = bus.dma_wr;
            bus.bus_addr  = bus.dma_addr;
            bus.bus_wdata = bus.dma_wdata;
        end else if (cpu_win) begin
            bus.bus_rd    = bus.cpu_rd;
            bus.bus_wr    = bus.cpu_wr;
            bus.bus_addr  = bus.cpu_addr;
            bus.bus_wdata = bus.cpu_wdata;
        end
        bus.cpu_rdata  = cpu_win ? bus.bus_rdata : '0;
        bus.cpu_stall  = reset && cpu_req && !cpu_win;
        bus.dma_gnt    = dma_win;
        bus.dma_rdata  = dma_rdata_q;
        bus.dma_rvalid = dma_rvalid_q;
        bus.owner      = owner_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            owner_q      <= OWN_CPU;
            dma_rdata_q  <= '0;
            dma_rvalid_q <= 1'b0;
        end else begin
            if (dma_win) begin
                owner_q <= OWN_DMA;
            end else if (cpu_win) begin
                owner_q <= OWN_CPU;
            end
            dma_rvalid_q <= dma_rd_grant;
            if (dma_rd_grant) begin
                dma_rdata_q <= bus.bus_rdata;
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter with a small Peripheral model
// (TL and switch readable, writes logged).
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    logic clk;
    logic reset;

    int checks = 0;
    int errors = 0;

    logic [31:0] tl_reg;
    logic [7:0]  sw;
    logic [31:0] led_q;
    int          wr_count = 0;
    int          wr_before;
    logic        exp_dma;

    bus_arbiter_if u_if ();

    bus_arbiter #(
        .STARVE_LIMIT (4),
        .BURST_MAX    (4)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (u_if.bus_addr)
            ADDR_TL:     u_if.bus_rdata = tl_reg;
            ADDR_SWITCH: u_if.bus_rdata = {24'h0, sw};
            default:     u_if.bus_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (u_if.bus_wr) begin
            wr_count <= wr_count + 1;
            if (u_if.bus_addr == ADDR_LED) led_q <= u_if.bus_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        u_if.cpu_rd    = 1'b0;
        u_if.cpu_wr    = 1'b0;
        u_if.cpu_addr  = '0;
        u_if.cpu_wdata = '0;
        u_if.dma_req   = 1'b0;
        u_if.dma_wr    = 1'b0;
        u_if.dma_addr  = '0;
        u_if.dma_wdata = '0;
    endtask

    initial begin
        tl_reg = 32'h0000_0123;
        sw     = 8'h00;
        led_q  = 32'h0;
        idle_inputs();

        // Reset held with both masters requesting
        reset         = 1'b0;
        u_if.cpu_rd   = 1'b1;
        u_if.cpu_addr = ADDR_SWITCH;
        u_if.dma_req  = 1'b1;
        u_if.dma_addr = ADDR_TL;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst bus_rd", 32'(u_if.bus_rd), 32'd0);
        check("rst bus_wr", 32'(u_if.bus_wr), 32'd0);
        check("rst bus_addr", u_if.bus_addr, 32'd0);
        check("rst cpu_stall", 32'(u_if.cpu_stall), 32'd0);
        check("rst dma_gnt", 32'(u_if.dma_gnt), 32'd0);
        check("rst cpu_rdata", u_if.cpu_rdata, 32'd0);
        check("rst dma_rvalid", 32'(u_if.dma_rvalid), 32'd0);
        check("rst dma_rdata", u_if.dma_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        #1;
        check("post-rst owner", 32'(u_if.owner), 32'd0);

        // CPU alone reads the switch register
        @(negedge clk);
        sw            = 8'hA5;
        u_if.cpu_rd   = 1'b1;
        u_if.cpu_addr = ADDR_SWITCH;
        #1;
        check("cpu rd bus_rd", 32'(u_if.bus_rd), 32'd1);
        check("cpu rd bus_addr", u_if.bus_addr, ADDR_SWITCH);
        check("cpu rd cpu_rdata", u_if.cpu_rdata, 32'h0000_00A5);
        check("cpu rd cpu_stall", 32'(u_if.cpu_stall), 32'd0);
        check("cpu rd dma_gnt", 32'(u_if.dma_gnt), 32'd0);

        // Continuous contention: CPU x4, DMA x4, CPU x4, DMA x4
        @(negedge clk);
        u_if.dma_req   = 1'b1;
        u_if.dma_wr    = 1'b1;
        u_if.dma_addr  = ADDR_DIGI;
        u_if.dma_wdata = 32'h0000_BEEF;
        for (int c = 0; c < 16; c++) begin
            exp_dma = ((c / 4) % 2) == 1;
            #1;
            check($sformatf("contend c%0d cpu_stall", c), 32'(u_if.cpu_stall), 32'(exp_dma));
            check($sformatf("contend c%0d dma_gnt", c), 32'(u_if.dma_gnt), 32'(exp_dma));
            check($sformatf("contend c%0d bus_wr", c), 32'(u_if.bus_wr), 32'(exp_dma));
            @(negedge clk);
        end
        idle_inputs();
        #1;
        check("idle bus_rd", 32'(u_if.bus_rd), 32'd0);
        check("idle bus_wr", 32'(u_if.bus_wr), 32'd0);
        check("idle bus_addr", u_if.bus_addr, 32'd0);
        check("after burst owner", 32'(u_if.owner), 32'd1);

        // DMA alone reads TL; rvalid pulses one cycle later
        @(negedge clk);
        u_if.dma_req  = 1'b1;
        u_if.dma_wr   = 1'b0;
        u_if.dma_addr = ADDR_TL;
        #1;
        check("dma rd gnt", 32'(u_if.dma_gnt), 32'd1);
        check("dma rd bus_rd", 32'(u_if.bus_rd), 32'd1);
        check("dma rd bus_addr", u_if.bus_addr, ADDR_TL);
        @(negedge clk);
        idle_inputs();
        #1;
        check("dma rd t+1 rvalid", 32'(u_if.dma_rvalid), 32'd1);
        check("dma rd t+1 rdata", u_if.dma_rdata, 32'h0000_0123);
        @(negedge clk);
        #1;
        check("dma rd t+2 rvalid", 32'(u_if.dma_rvalid), 32'd0);
        check("dma rd t+2 rdata hold", u_if.dma_rdata, 32'h0000_0123);

        // Lone DMA write burst of 10 cycles; CPU write arrives at cycle 7
        @(negedge clk);
        wr_before = wr_count;
        for (int b = 1; b <= 10; b++) begin
            u_if.dma_req   = 1'b1;
            u_if.dma_wr    = 1'b1;
            u_if.dma_addr  = ADDR_DIGI;
            u_if.dma_wdata = 32'(b);
            u_if.cpu_wr    = (b == 7);
            u_if.cpu_addr  = ADDR_LED;
            u_if.cpu_wdata = 32'h0000_005A;
            #1;
            check($sformatf("burst b%0d dma_gnt", b), 32'(u_if.dma_gnt), 32'(b != 7));
            check($sformatf("burst b%0d bus_wr", b), 32'(u_if.bus_wr), 32'd1);
            if (b == 7) begin
                check("burst b7 cpu_stall", 32'(u_if.cpu_stall), 32'd0);
                check("burst b7 bus_addr", u_if.bus_addr, ADDR_LED);
            end
            if (b == 8) check("burst b8 owner", 32'(u_if.owner), 32'd0);
            @(negedge clk);
        end
        idle_inputs();
        #1;
        check("burst write count", 32'(wr_count - wr_before), 32'd10);
        check("burst cpu led write", led_q, 32'h0000_005A);
        check("burst end owner", 32'(u_if.owner), 32'd1);

        // Reset asserted during beat 2 of a DMA read burst
        @(negedge clk);
        u_if.dma_req  = 1'b1;
        u_if.dma_wr   = 1'b0;
        u_if.dma_addr = ADDR_TL;
        #1;
        check("abort beat1 gnt", 32'(u_if.dma_gnt), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort beat2 gnt", 32'(u_if.dma_gnt), 32'd0);
        check("abort beat2 bus_rd", 32'(u_if.bus_rd), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        #1;
        check("abort rvalid", 32'(u_if.dma_rvalid), 32'd0);
        check("abort rdata", u_if.dma_rdata, 32'd0);
        check("abort owner", 32'(u_if.owner), 32'd0);

        // Counters cleared by reset: contention must again give the CPU four cycles first
        @(negedge clk);
        u_if.cpu_rd   = 1'b1;
        u_if.cpu_addr = ADDR_SWITCH;
        u_if.dma_req  = 1'b1;
        u_if.dma_wr   = 1'b1;
        u_if.dma_addr = ADDR_DIGI;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("post-abort c%0d dma_gnt", c), 32'(u_if.dma_gnt), 32'(c == 4));
            @(negedge clk);
        end
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Shares the single data bus (rd/wr/addr/wdata/rdata) into the Peripheral/DataMem block between two masters: the CPU data port and a DMA master (UART loader). Arbitration and grant are same-cycle; the bus is combinational-read and posedge-write. Registered state bounds DMA bursts and CPU starvation of DMA. The block sits between the CPU/DMA and Peripheral and drives Peripheral's rd/wr/addr/wdata.

Parameters:
STARVE_LIMIT, 4, number of consecutive CPU grants while dma_req is pending before DMA is forced to win (1..15)
BURST_MAX, 4, maximum consecutive DMA grants while the CPU is requesting (1..15)

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-low
cpu_rd  input  1  CPU read request
cpu_wr  input  1  CPU write request
cpu_addr  input  32  CPU address
cpu_wdata  input  32  CPU write data
cpu_rdata  output  32  CPU read data; bus_rdata when CPU granted, else 0
cpu_stall  output  1  CPU request present but not granted this cycle
dma_req  input  1  DMA access request
dma_wr  input  1  DMA direction: 1 = write, 0 = read
dma_addr  input  32  DMA address
dma_wdata  input  32  DMA write data
dma_gnt  output  1  DMA beat completes this cycle
dma_rdata  output  32  registered read data for the last granted DMA read
dma_rvalid  output  1  1-cycle pulse, one cycle after a granted DMA read
bus_rd  output  1  to Peripheral rd
bus_wr  output  1  to Peripheral wr
bus_addr  output  32  to Peripheral addr
bus_wdata  output  32  to Peripheral wdata
bus_rdata  input  32  from Peripheral rdata
owner  output  1  registered last owner (0 = CPU, 1 = DMA)

Behaviour:
- cpu_req = cpu_rd | cpu_wr. State: owner_q, burst_cnt[3:0], starve_cnt[3:0], dma_rdata_q, dma_rvalid_q.
- Reset (reset == 0 sampled at posedge): owner_q = CPU, counters = 0, dma_rdata = 0, dma_rvalid = 0.
- While reset is low, combinational outputs are forced: bus_rd = bus_wr = 0, bus_addr = bus_wdata = 0, cpu_stall = 0, dma_gnt = 0, cpu_rdata = 0.
- Grant decision is combinational each cycle:
  - Only one master requesting: that master wins.
  - Both requesting: DMA wins if (owner_q == DMA and burst_cnt < BURST_MAX) or starve_cnt == STARVE_LIMIT. Otherwise CPU wins.
  - No requests: bus idle, all bus outputs 0.
- Winner's rd/wr/addr/wdata are muxed to bus_*. A DMA grant drives bus_rd = ~dma_wr and bus_wr = dma_wr.
- cpu_stall = cpu_req & ~cpu_win. dma_gnt = dma_req & dma_win.
- Posedge updates (reset high):
  - owner_q <= winner; unchanged when idle.
  - burst_cnt: +1 on a DMA grant, saturating at BURST_MAX; cleared on any cycle without a DMA grant.
  - starve_cnt: +1 on a CPU grant with dma_req = 1, saturating at STARVE_LIMIT; cleared on a DMA grant or when dma_req = 0.
  - On a DMA read grant: dma_rdata <= bus_rdata and dma_rvalid <= 1. Otherwise dma_rvalid <= 0; dma_rdata holds.
- Burst limit applies only under contention. A lone DMA is granted every cycle, and burst_cnt saturates.
- A CPU request arriving while burst_cnt == BURST_MAX wins immediately.
- Reset mid-burst aborts: no grant in the reset cycle, and no rvalid afterwards.
- Masters must hold request and fields stable until granted (cpu_stall low / dma_gnt high). The arbiter does not latch pending requests.

Decomposition:
- Shared package: OWN_CPU = 1'b0, OWN_DMA = 1'b1; peripheral address constants (TH 0x40000000 … DIGI 0x40000014) for benches.
- One sub-module: arb_sat_counter (width, limit, inc, clr, sync active-low reset, count/at_limit), instantiated for burst_cnt and starve_cnt.

Test Plan:
- Reset held low with cpu_rd = 1 and dma_req = 1 -> bus_rd = bus_wr = 0, cpu_stall = 0, dma_gnt = 0. After release, owner = 0.
- CPU alone reads 0x40000010 with switch = 8'hA5 -> bus_rd = 1, cpu_rdata = 32'h000000A5 same cycle, cpu_stall = 0.
- CPU and DMA request continuously from idle (defaults) -> CPU granted cycles 0–3, DMA cycles 4–7, CPU 8–11, DMA 12–15. cpu_stall = 1 exactly in DMA cycles.
- DMA alone reads 0x40000004 at cycle t with TL = 32'h00000123 -> dma_gnt = 1 at t; at t+1 dma_rvalid = 1, dma_rdata = 32'h00000123; at t+2 rvalid = 0.
- DMA alone for 10 writes, CPU write arriving at beat 7 -> beats 1–6 granted, CPU wins at beat 7 (burst_cnt = 4), DMA resumes next cycle.
- reset pulled low during DMA beat 2 of a burst -> dma_gnt = 0 that cycle; afterwards counters = 0, dma_rvalid = 0, owner = 0.
